// File: rtl/ucq_pkg.sv
// ----------------------------------------------------------------------------
// ucq_pkg
// Shared constants and types for the unit-clause queue.
//   UCQ_SIZE  : default number of queue entries (power of two, >= 2)
//   UC_LENGTH : default literal index space
//   LIT_W     : literal width, index bits plus one polarity bit
//   PTR_W     : pointer width, entry index plus one wrap bit
//   lit_t     : literal at the default width
//   ucq_ptr_t : head/tail pointer at the default size
// ----------------------------------------------------------------------------
package ucq_pkg;

    localparam int UCQ_SIZE  = 4;
    localparam int UC_LENGTH = 1024;
    localparam int LIT_W     = $clog2(UC_LENGTH) + 1;
    localparam int PTR_W     = $clog2(UCQ_SIZE) + 1;

    typedef logic [LIT_W-1:0] lit_t;
    typedef logic [PTR_W-1:0] ucq_ptr_t;

endpackage : ucq_pkg

// File: rtl/unit_clause_queue.sv
// ----------------------------------------------------------------------------
// unit_clause_queue
// Circular first-word-fall-through FIFO buffering unit-clause literals from
// the unit-clause arbiter to one propagation engine.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous reset, active low
//   push     in   enqueue request (dropped when full)
//   pop      in   dequeue request (ignored when empty)
//   uca2ucq  in   literal to enqueue
//   empty    out  queue holds no entries
//   full     out  queue holds QUEUE_SIZE entries
//   ucq2eng  out  head literal, 0 while empty
//
// Build option UCQ_DEBUG_EN: when defined, adds the ports entry_r, entry_w,
// head_r, head_w, tail_r, tail_w exposing current and next internal state.
// Behaviour is identical with or without it.
// ----------------------------------------------------------------------------
module unit_clause_queue #(
    parameter  int QUEUE_SIZE = ucq_pkg::UCQ_SIZE,
    parameter  int UC_LENGTH  = ucq_pkg::UC_LENGTH,
    localparam int LIT_W      = $clog2(UC_LENGTH) + 1,
    localparam int PTR_W      = $clog2(QUEUE_SIZE) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic                              pop,
    input  logic [LIT_W-1:0]                  uca2ucq,
    output logic                              empty,
    output logic                              full,
    output logic [LIT_W-1:0]                  ucq2eng
`ifdef UCQ_DEBUG_EN
    ,
    output logic [QUEUE_SIZE-1:0][LIT_W-1:0]  entry_r,
    output logic [QUEUE_SIZE-1:0][LIT_W-1:0]  entry_w,
    output logic [PTR_W-1:0]                  head_r,
    output logic [PTR_W-1:0]                  head_w,
    output logic [PTR_W-1:0]                  tail_r,
    output logic [PTR_W-1:0]                  tail_w
`endif
);

    import ucq_pkg::*;

    localparam int IDX_W = PTR_W - 1;

    logic [QUEUE_SIZE-1:0][LIT_W-1:0] entry_q, entry_d;
    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [QUEUE_SIZE-1:0]            wr_en;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             empty_int;
    logic             full_int;
    logic             push_ok;
    logic             pop_ok;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    // Pointers carry one extra wrap bit so that equal indices can be told
    // apart as "nothing stored" versus "every slot stored".
    assign empty_int = (head_q == tail_q);
    assign full_int  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

    // Acceptance uses only the registered flags, so a push and a pop in the
    // same cycle are judged independently against the pre-edge occupancy.
    assign push_ok = push & ~full_int;
    assign pop_ok  = pop  & ~empty_int;

    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (tail_idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (wr_en[i]) begin
                entry_d[i] = uca2ucq;
            end
        end
        // Dequeued slots are left as-is; they are overwritten on reuse.
        head_d = head_q + PTR_W'(pop_ok);
        tail_d = tail_q + PTR_W'(push_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Outputs depend on registered state only.
    assign empty   = empty_int;
    assign full    = full_int;
    assign ucq2eng = empty_int ? '0 : entry_q[head_idx];

`ifdef UCQ_DEBUG_EN
    assign entry_r = entry_q;
    assign entry_w = entry_d;
    assign head_r  = head_q;
    assign head_w  = head_d;
    assign tail_r  = tail_q;
    assign tail_w  = tail_d;
`endif

endmodule : unit_clause_queue

// File: tb/tb_unit_clause_queue.sv
// ----------------------------------------------------------------------------
// tb_unit_clause_queue
// Directed vector table for the fill/drain/wrap/simultaneous cases, a
// hand-written asynchronous-reset sequence, then randomized traffic checked
// against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_unit_clause_queue;

    localparam int QS    = 4;
    localparam int LIT_W = 11;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [LIT_W-1:0] uca2ucq;
    logic             empty;
    logic             full;
    logic [LIT_W-1:0] ucq2eng;

`ifdef UCQ_DEBUG_EN
    logic [QS-1:0][LIT_W-1:0] entry_r, entry_w;
    logic [PTR_W-1:0]         head_r, head_w, tail_r, tail_w;
`endif

    unit_clause_queue #(.QUEUE_SIZE(QS), .UC_LENGTH(1024)) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .uca2ucq (uca2ucq),
        .empty   (empty),
        .full    (full),
        .ucq2eng (ucq2eng)
`ifdef UCQ_DEBUG_EN
        ,
        .entry_r (entry_r),
        .entry_w (entry_w),
        .head_r  (head_r),
        .head_w  (head_w),
        .tail_r  (tail_r),
        .tail_w  (tail_w)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic             push;
        logic             pop;
        logic [LIT_W-1:0] din;
        logic             exp_empty;
        logic             exp_full;
        logic [LIT_W-1:0] exp_out;
    } vec_t;

    vec_t vecs[$];

    // Reference model: plain list of stored literals, oldest first.
    int model_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e, input logic f,
                                 input logic [LIT_W-1:0] o);
        check({tag, ".empty"},   int'(empty),   int'(e));
        check({tag, ".full"},    int'(full),    int'(f));
        check({tag, ".ucq2eng"}, int'(ucq2eng), int'(o));
    endtask

    task automatic add(input logic p, input logic q, input int d,
                       input logic e, input logic f, input int o);
        vec_t v;
        v.push = p; v.pop = q; v.din = LIT_W'(d);
        v.exp_empty = e; v.exp_full = f; v.exp_out = LIT_W'(o);
        vecs.push_back(v);
    endtask

    // Apply one cycle of inputs; return 1 ns after the active edge.
    task automatic drive_cycle(input logic p, input logic q, input logic [LIT_W-1:0] d);
        push = p; pop = q; uca2ucq = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    initial begin
        rst = 1'b0; push = 1'b0; pop = 1'b0; uca2ucq = '0;

        // Reset held across an edge.
        @(posedge clk); #1;
        check_outputs("in_reset", 1'b1, 1'b0, '0);
        rst = 1'b1;

        // push pop din | empty full out   (expected after the edge)
        add(0,0, 0, 1,0,0);                       // idle
        add(1,0, 2, 0,0,2);  add(1,0, 4, 0,0,2);  // fill
        add(1,0, 6, 0,0,2);  add(1,0, 8, 0,1,2);
        add(1,0,10, 0,1,2);                       // dropped
        add(0,1, 0, 0,0,4);  add(0,1, 0, 0,0,6);  // drain
        add(0,1, 0, 0,0,8);  add(0,1, 0, 1,0,0);
        add(0,1, 0, 1,0,0);                       // pop while empty
        add(1,0, 1, 0,0,1);  add(1,0, 2, 0,0,1);  // wrap-around
        add(0,1, 0, 0,0,2);  add(1,0, 3, 0,0,2);
        add(1,0, 4, 0,0,2);  add(0,1, 0, 0,0,3);
        add(1,0, 5, 0,0,3);  add(1,0, 6, 0,1,3);
        add(0,1, 0, 0,0,4);  add(0,1, 0, 0,0,5);
        add(0,1, 0, 0,0,6);  add(0,1, 0, 1,0,0);
        add(1,0, 3, 0,0,3);  add(1,0, 5, 0,0,3);  // simultaneous, mid
        add(1,1, 7, 0,0,5);
        add(1,0,11, 0,0,5);  add(1,0,13, 0,1,5);  // simultaneous, full
        add(1,1, 9, 0,0,7);
        add(0,1, 0, 0,0,11); add(0,1, 0, 0,0,13);
        add(0,1, 0, 1,0,0);
        add(1,1, 9, 0,0,9);                       // simultaneous, empty
        add(0,1, 0, 1,0,0);

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].push, vecs[i].pop, vecs[i].din);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_empty,
                          vecs[i].exp_full, vecs[i].exp_out);
        end

        // Asynchronous reset between edges with three entries stored.
        drive_cycle(1'b1, 1'b0, 11'd20);
        drive_cycle(1'b1, 1'b0, 11'd21);
        drive_cycle(1'b1, 1'b0, 11'd22);
        check_outputs("pre_async", 1'b0, 1'b0, 11'd20);
        #2 rst = 1'b0;
        #1;
        check_outputs("async_rst", 1'b1, 1'b0, '0);
        #1 rst = 1'b1;
        drive_cycle(1'b1, 1'b0, 11'd12);
        check_outputs("after_async", 1'b0, 1'b0, 11'd12);
        drive_cycle(1'b0, 1'b1, 11'd0);
        check_outputs("after_async_pop", 1'b1, 1'b0, '0);

        // Randomized traffic against the reference model.
        model_q.delete();
        for (int n = 0; n < 3000; n++) begin
            logic             p, q;
            logic [LIT_W-1:0] d;
            bit               do_pop, do_push;
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_q.delete();
                check_outputs("rnd_async_rst", 1'b1, 1'b0, '0);
                #1 rst = 1'b1;
            end
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 50);
            d = LIT_W'($urandom);
            do_pop  = q && (model_q.size() > 0);
            do_push = p && (model_q.size() < QS);
            drive_cycle(p, q, d);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(int'(d));
            check_outputs($sformatf("rnd%0d", n), model_q.size() == 0,
                          model_q.size() == QS,
                          (model_q.size() == 0) ? '0 : LIT_W'(model_q[0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_unit_clause_queue
